// File: rtl/washer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : washer_pkg
// Description : Shared types and constants for the washer water-flow path.
// Revision    : 1.0 - initial release
// ============================================================================
package washer_pkg;

    localparam int   LEVEL_W    = 10;
    localparam logic MODE_FILL  = 1'b1;
    localparam logic MODE_DRAIN = 1'b0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BASELINE = 2'd1,
        WATCH    = 2'd2,
        ERROR    = 2'd3
    } flow_state_t;

endpackage
`default_nettype wire

// File: rtl/water_flow_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : water_flow_monitor_if
// Description : Controller <-> flow monitor request/status bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface water_flow_monitor_if;
    import washer_pkg::*;

    logic               water_flow_reset;
    logic               water_flow_mode;
    logic [LEVEL_W-1:0] water_level_sensor;
    logic [LEVEL_W-1:0] target_level;
    logic [LEVEL_W-1:0] water_level;
    logic               water_flow_error;

    modport master (
        output water_flow_reset,
        output water_flow_mode,
        output water_level_sensor,
        output target_level,
        input  water_level,
        input  water_flow_error
    );

    modport slave (
        input  water_flow_reset,
        input  water_flow_mode,
        input  water_level_sensor,
        input  target_level,
        output water_level,
        output water_flow_error
    );

endinterface
`default_nettype wire

// File: rtl/water_flow_monitor_level_avg4.sv
`default_nettype none
// ============================================================================
// Module      : level_avg4
// Description : 4-tap moving average of the raw level sensor, truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module level_avg4
    import washer_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic [LEVEL_W-1:0] din,
    output logic      [LEVEL_W-1:0] dout
);

    logic [LEVEL_W-1:0] r_h0;
    logic [LEVEL_W-1:0] r_h1;
    logic [LEVEL_W-1:0] r_h2;
    logic [LEVEL_W+1:0] w_sum;

    // Two guard bits keep the four-sample sum exact before the divide.
    assign w_sum = {2'b00, din} + {2'b00, r_h0} + {2'b00, r_h1} + {2'b00, r_h2};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h0 <= '0;
            r_h1 <= '0;
            r_h2 <= '0;
            dout <= '0;
        end else begin
            r_h0 <= din;
            r_h1 <= r_h0;
            r_h2 <= r_h1;
            dout <= w_sum[LEVEL_W+1:2];
        end
    end

endmodule
`default_nettype wire

// File: rtl/water_flow_monitor.sv
`default_nettype none
// ============================================================================
// Module      : water_flow_monitor
// Description : Filters water level and raises a sticky error on flow stall.
// Revision    : 1.0 - initial release
// ============================================================================
module water_flow_monitor
    import washer_pkg::*;
#(
    parameter int TICK_DIV     = 10,
    parameter int WINDOW_TICKS = 5,
    parameter int MIN_DELTA    = 10
) (
    input wire logic             clk,
    input wire logic             reset,
    water_flow_monitor_if.slave  flow
);

    localparam int c_presc_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_tick_w  = $clog2(WINDOW_TICKS + 1);
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_DIV - 1);
    localparam logic [c_tick_w-1:0]  c_window     = c_tick_w'(WINDOW_TICKS);
    localparam logic [LEVEL_W:0]     c_delta      = (LEVEL_W + 1)'(MIN_DELTA);

    flow_state_t          r_state;
    flow_state_t          w_state_next;
    logic [LEVEL_W-1:0]   r_ref;
    logic [LEVEL_W-1:0]   w_ref_next;
    logic [c_presc_w-1:0] r_presc;
    logic [c_presc_w-1:0] w_presc_next;
    logic [c_tick_w-1:0]  r_tick_cnt;
    logic [c_tick_w-1:0]  w_tick_next;
    logic [c_tick_w-1:0]  w_tick_inc;
    logic                 r_prev_mode;
    logic                 r_error;
    logic [LEVEL_W-1:0]   w_level;
    logic [LEVEL_W:0]     w_level_ext;
    logic [LEVEL_W:0]     w_ref_ext;
    logic                 w_wrap;
    logic                 w_progress;

    level_avg4 u_level_avg4 (
        .clk   (clk),
        .reset (reset),
        .din   (flow.water_level_sensor),
        .dout  (w_level)
    );

    assign flow.water_level      = w_level;
    assign flow.water_flow_error = r_error;

    assign w_level_ext = {1'b0, w_level};
    assign w_ref_ext   = {1'b0, r_ref};
    assign w_wrap      = (r_presc == c_presc_last);
    assign w_tick_inc  = r_tick_cnt + 1'b1;

    // Reaching the fill target or an empty drum counts as progress on its own.
    always_comb begin
        w_progress = 1'b0;
        if (flow.water_flow_mode == MODE_FILL) begin
            w_progress = (w_level_ext >= w_ref_ext + c_delta) ||
                         (w_level >= flow.target_level);
        end else begin
            w_progress = (w_level_ext + c_delta <= w_ref_ext) ||
                         (w_level == '0);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ref_next   = r_ref;
        w_presc_next = r_presc;
        w_tick_next  = r_tick_cnt;
        if (flow.water_flow_reset) begin
            w_state_next = IDLE;
            w_ref_next   = '0;
            w_presc_next = '0;
            w_tick_next  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_next = BASELINE;
                end
                BASELINE: begin
                    w_ref_next   = w_level;
                    w_presc_next = '0;
                    w_tick_next  = '0;
                    w_state_next = WATCH;
                end
                WATCH: begin
                    // Mode change re-arms the window before progress/timeout are judged.
                    if (flow.water_flow_mode != r_prev_mode) begin
                        w_state_next = BASELINE;
                    end else if (w_progress) begin
                        w_ref_next   = w_level;
                        w_presc_next = '0;
                        w_tick_next  = '0;
                    end else if (w_wrap) begin
                        w_presc_next = '0;
                        if (w_tick_inc == c_window) begin
                            w_state_next = ERROR;
                        end else begin
                            w_tick_next = w_tick_inc;
                        end
                    end else begin
                        w_presc_next = r_presc + 1'b1;
                    end
                end
                ERROR: begin
                    w_state_next = ERROR;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_ref       <= '0;
            r_presc     <= '0;
            r_tick_cnt  <= '0;
            r_prev_mode <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ref       <= w_ref_next;
            r_presc     <= w_presc_next;
            r_tick_cnt  <= w_tick_next;
            r_prev_mode <= flow.water_flow_mode;
            r_error     <= (w_state_next == ERROR);
        end
    end

endmodule
`default_nettype wire
